// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [2:0] TXDATA_OFF = 3'd0;
    localparam logic [2:0] STATUS_OFF = 3'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 4;

    function automatic logic [31:0] pack_status(input logic [3:0] count,
                                                input logic       ovf,
                                                input logic       busy,
                                                input logic       empty,
                                                input logic       full);
        logic [31:0] s;
        s                  = '0;
        s[ST_FULL]         = full;
        s[ST_EMPTY]        = empty;
        s[ST_BUSY]         = busy;
        s[ST_OVF]          = ovf;
        s[ST_COUNT +: 4]   = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A simultaneous pop frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and pollable STATUS register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 12_000_000,
    parameter int          BAUD       = 115_200,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        txd,
    output logic        busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    uart_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          ovf;

    logic          sel;
    logic          is_status;
    logic          data_wr;
    logic          status_wr;
    logic          pop;
    logic          baud_last;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count4;
    logic          unused_ok;

    assign sel       = (address[31:3] == BASE_ADDR[31:3]);
    assign is_status = (address[2] == STATUS_OFF[2]);
    assign data_wr   = write_mem && sel && !is_status;
    assign status_wr = write_mem && sel && is_status;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign baud_last = (baud == BW'(DIV - 1));
    assign busy      = (state != IDLE) || !fifo_empty;
    assign count4    = 4'(fifo_count);
    assign unused_ok = ^{funct3, address[1:0], write_data[31:8]};

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (data_wr),
        .pop  (pop),
        .din  (write_data[7:0]),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // Register reads mirror mem: one cycle of latency, TXDATA reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
            hit       <= 1'b0;
        end else begin
            hit       <= sel;
            read_data <= (sel && is_status)
                         ? pack_status(count4, ovf, busy, fifo_empty, fifo_full)
                         : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (data_wr && fifo_full && !pop)
            ovf <= 1'b1;
        else if (status_wr)
            ovf <= 1'b0;
    end

`ifdef UART_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (reset)
            par <= 1'b0;
        else if (pop)
            par <= ^fifo_dout;
    end
`endif

    // txd is registered and updated together with the state, so each level
    // appears on the line the edge its state is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            txd    <= 1'b1;
            baud   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg <= fifo_dout;
                        baud  <= '0;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud   <= '0;
                        bitcnt <= '0;
                        state  <= DATA;
                        txd    <= shreg[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud  <= '0;
                        shreg <= shreg >> 1;
                        if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= par;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                            txd    <= shreg[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= STOP;
                        txd   <= 1'b1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= IDLE;
                        txd   <= 1'b1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register table, directed corner cases,
// and random bus traffic compared against a frame-level reference model.
module tb_mmio_uart_tx;

    localparam int          DIV  = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_mem = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        hit;
    logic        txd;
    logic        busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLK_HZ    (1_000_000),
        .BAUD      (250_000),
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write_mem (write_mem),
        .funct3    (funct3),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .hit       (hit),
        .txd       (txd),
        .busy      (busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queued bytes plus the list of line levels still to come.
    logic [7:0]  fifo_m[$];
    bit          wave_m[$];
    bit          ovf_m = 1'b0;
    logic        txd_m = 1'b1;
    logic        hit_m = 1'b0;
    logic [31:0] rd_m = '0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelBusy();
        return (wave_m.size() != 0) || (fifo_m.size() != 0);
    endfunction

    task automatic modelEdge(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rst);
        bit         sel;
        bit         pop;
        logic [7:0] b;
        if (rst) begin
            fifo_m = {};
            wave_m = {};
            ovf_m  = 1'b0;
            txd_m  = 1'b1;
            hit_m  = 1'b0;
            rd_m   = '0;
        end else begin
            sel   = (a[31:3] == BASE[31:3]);
            hit_m = sel;
            if (sel && a[2])
                rd_m = {24'b0, 4'(fifo_m.size()), ovf_m, modelBusy(),
                        fifo_m.size() == 0, fifo_m.size() == 8};
            else
                rd_m = '0;
            pop = (wave_m.size() == 0) && (fifo_m.size() != 0);
            if (wave_m.size() != 0) begin
                txd_m = wave_m.pop_front();
            end else if (pop) begin
                b = fifo_m.pop_front();
                repeat (DIV) wave_m.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    repeat (DIV) wave_m.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                repeat (DIV) wave_m.push_back(^b);
`endif
                repeat (DIV) wave_m.push_back(1'b1);
                wave_m.push_back(1'b1);
                txd_m = wave_m.pop_front();
            end else begin
                txd_m = 1'b1;
            end
            if (we && sel && !a[2]) begin
                if (fifo_m.size() < 8)
                    fifo_m.push_back(d[7:0]);
                else
                    ovf_m = 1'b1;
            end else if (we && sel && a[2]) begin
                ovf_m = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("txd", {31'b0, txd}, {31'b0, txd_m});
        checkValue("busy", {31'b0, busy}, {31'b0, modelBusy()});
        checkValue("hit", {31'b0, hit}, {31'b0, hit_m});
        checkValue("read_data", read_data, rd_m);
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f3, input bit rst);
        @(negedge clk);
        write_mem  = we;
        address    = a;
        write_data = d;
        funct3     = f3;
        reset      = rst;
        @(posedge clk);
        modelEdge(we, a, d, rst);
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    endtask

    task automatic storeByte(input logic [7:0] v);
        applyStimulus(1'b1, BASE, {24'h0, v}, 3'b000, 1'b0);
    endtask

    task automatic readStatus();
        applyStimulus(1'b0, BASE + 32'd4, 32'h0, 3'b010, 1'b0);
    endtask

    task automatic waitTxdLow(input int bound, input string name);
        int n = 0;
        while (txd !== 1'b0 && n < bound) begin
            idle();
            n++;
        end
        checkValue(name, {31'b0, txd}, 32'h0);
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            idle();
            n++;
        end
        checkValue(name, {31'b0, busy}, 32'h0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];
    bit   s_txd[64];
    bit   s_busy[64];

    initial begin
        logic [9:0] pat;
        logic [7:0] got;
        bit         bad;
        int         n;

        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        checkValue("reset_txd", {31'b0, txd}, 32'h1);
        checkValue("reset_busy", {31'b0, busy}, 32'h0);
        checkValue("reset_hit", {31'b0, hit}, 32'h0);
        checkValue("reset_read_data", read_data, 32'h0);

        // Register decode from the empty, idle state.
        vecs[0] = '{1'b0, 32'h0000_2004, 32'h0,         1'b1, 32'h02};
        vecs[1] = '{1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h00};
        vecs[2] = '{1'b0, 32'h0000_2008, 32'h0,         1'b0, 32'h00};
        vecs[3] = '{1'b0, 32'h0000_1FFC, 32'h0,         1'b0, 32'h00};
        vecs[4] = '{1'b1, 32'h0000_2008, 32'h77,        1'b0, 32'h00};
        vecs[5] = '{1'b1, 32'h0000_2006, 32'hFFFF_FFFF, 1'b1, 32'h02};
        vecs[6] = '{1'b0, 32'h8000_2004, 32'h0,         1'b0, 32'h00};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, 3'b010, 1'b0);
            checkValue($sformatf("tbl%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
            checkValue($sformatf("tbl%0d_rd", i), read_data, vecs[i].exp_rd);
        end
        readStatus();
        checkValue("tbl_no_push", read_data, 32'h02);

        $display("[TB] single frame 0x55");
        storeByte(8'h55);
        checkValue("t1_txd_after_write", {31'b0, txd}, 32'h1);
        idle();
        s_txd[0]  = txd;
        s_busy[0] = busy;
        for (int i = 1; i <= FRAME; i++) begin
            idle();
            s_txd[i]  = txd;
            s_busy[i] = busy;
        end
        pat = 10'b10_1010_1010;
        for (int i = 0; i < FRAME; i++) begin
            if (i < 9 * DIV)
                checkValue($sformatf("t1_level%0d", i), {31'b0, s_txd[i]}, {31'b0, pat[i / DIV]});
            else if (i >= FRAME - DIV)
                checkValue($sformatf("t1_stop%0d", i), {31'b0, s_txd[i]}, 32'h1);
            else
                checkValue($sformatf("t1_parity%0d", i), {31'b0, s_txd[i]}, 32'h0);
        end
        checkValue("t1_busy_last", {31'b0, s_busy[FRAME - 1]}, 32'h1);
        checkValue("t1_busy_drop", {31'b0, s_busy[FRAME]}, 32'h0);

        $display("[TB] overflow");
        for (int i = 0; i < 10; i++)
            storeByte(8'h30 + 8'(i));
        readStatus();
        checkValue("t2_status_ovf", read_data, 32'h8D);
        applyStimulus(1'b1, BASE + 32'd4, 32'h1234_5678, 3'b010, 1'b0);
        readStatus();
        checkValue("t2_status_cleared", read_data, 32'h85);
        waitIdle(600, "t2_drain_timeout");

        $display("[TB] wide store");
        applyStimulus(1'b1, BASE, 32'hDEAD_BEA5, 3'b010, 1'b0);
        waitTxdLow(10, "t3_start_timeout");
        got = '0;
        for (int b = 0; b < 8; b++) begin
            repeat ((b == 0) ? 6 : 4) idle();
            got[b] = txd;
        end
        checkValue("t3_byte", {24'b0, got}, 32'hA5);
        waitIdle(200, "t3_idle_timeout");

        $display("[TB] reset mid-frame");
        storeByte(8'h3C);
        storeByte(8'h81);
        waitTxdLow(10, "t4_start_timeout");
        repeat (17) idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        checkValue("t4_txd_reset", {31'b0, txd}, 32'h1);
        readStatus();
        checkValue("t4_status", read_data, 32'h02);
        bad = 1'b0;
        repeat (60) begin
            idle();
            if (txd !== 1'b1)
                bad = 1'b1;
        end
        checkValue("t4_no_frame", {31'b0, bad}, 32'h0);

        $display("[TB] push at pop edge");
        storeByte(8'h11);
        for (int i = 0; i < 8; i++)
            storeByte(8'h20 + 8'(i));
        n = 0;
        while (wave_m.size() != 0 && n < 100) begin
            idle();
            n++;
        end
        checkValue("t5_reach_pop_timeout", {31'b0, wave_m.size() != 0}, 32'h0);
        storeByte(8'h99);
        readStatus();
        checkValue("t5_status", read_data, 32'h85);
        waitIdle(600, "t5_drain_timeout");

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frame 0x07");
        storeByte(8'h07);
        idle();
        s_txd[0]  = txd;
        s_busy[0] = busy;
        for (int i = 1; i <= FRAME; i++) begin
            idle();
            s_txd[i]  = txd;
            s_busy[i] = busy;
        end
        checkValue("par_bit", {31'b0, s_txd[8 * DIV + DIV + 2]}, 32'h1);
        checkValue("par_busy_end", {31'b0, s_busy[43]}, 32'h1);
        checkValue("par_busy_drop", {31'b0, s_busy[44]}, 32'h0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            int          r;
            int          sa;
            logic [31:0] a;
            r  = $urandom_range(0, 199);
            sa = $urandom_range(0, 9);
            if (sa < 6)
                a = BASE;
            else if (sa < 9)
                a = BASE + 32'd4;
            else
                a = $urandom;
            applyStimulus(r < 20, a, $urandom, 3'($urandom_range(0, 7)), r == 0);
        end
        waitIdle(900, "rand_drain_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
